// File: rtl/button_sequence_capture.sv
// Button sequence capture: turns single-button edge pulses into a packed code
// of DIGITS indices. Multi-button presses and inactivity abort the entry.
// Every output is a register updated alongside the FSM state.
module button_sequence_capture #(
    parameter int WIDTH          = 4,
    parameter int DIGITS         = 4,
    parameter int INDEX_WIDTH    = 2,
    parameter int COUNT_WIDTH    = 3,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int TIMER_WIDTH    = 26
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              buttonEdge,
    input  logic                          clear,
    output logic [DIGITS*INDEX_WIDTH-1:0] code,
    output logic                          codeValid,
    output logic                          entryError,
    output logic [COUNT_WIDTH-1:0]        digitCount,
    output logic                          busy
);

    typedef enum logic [1:0] {IDLE, ENTRY, DONE, ERROR} state_t;

    localparam int CW = DIGITS * INDEX_WIDTH;

    state_t                 state;
    logic [TIMER_WIDTH-1:0] timer;

    logic                   any_press;
    logic                   multi_press;
    logic                   valid_press;
    logic [INDEX_WIDTH-1:0] press_idx;
    logic [CW-1:0]          code_first;
    logic [CW-1:0]          code_ins;
    logic [COUNT_WIDTH-1:0] count_inc;
    logic                   timed_out;

    // Classify the edge vector: x & (x-1) is nonzero iff two or more bits are set.
    always_comb begin
        any_press   = |buttonEdge;
        multi_press = |(buttonEdge & (buttonEdge - WIDTH'(1)));
        valid_press = any_press && !multi_press;
    end

    // Encode the pressed bit position; only meaningful for a valid press.
    always_comb begin
        press_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (buttonEdge[i]) press_idx = INDEX_WIDTH'(i);
        end
    end

    // Candidate code words: a fresh code with digit 0 in the MS field, and the
    // current code with the new digit dropped into slot digitCount.
    always_comb begin
        code_first = '0;
        code_first[CW-1 -: INDEX_WIDTH] = press_idx;
        code_ins = code;
        for (int k = 0; k < DIGITS; k++) begin
            if (digitCount == COUNT_WIDTH'(k))
                code_ins[(DIGITS-k)*INDEX_WIDTH-1 -: INDEX_WIDTH] = press_idx;
        end
    end

    // Timer holds cycles since the last registered press, so it reaches
    // TIMEOUT_CYCLES-1 just before the edge that must enter ERROR.
    always_comb begin
        count_inc = digitCount + COUNT_WIDTH'(1);
        timed_out = (timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));
    end

    // Main FSM with registered outputs; clear overrides every transition.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            code       <= '0;
            codeValid  <= 1'b0;
            entryError <= 1'b0;
            digitCount <= '0;
            busy       <= 1'b0;
            timer      <= '0;
        end else begin
            codeValid  <= 1'b0;
            entryError <= 1'b0;
            if (clear) begin
                state      <= IDLE;
                code       <= '0;
                digitCount <= '0;
                busy       <= 1'b0;
                timer      <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        timer <= '0;
                        if (multi_press) begin
                            state      <= ERROR;
                            entryError <= 1'b1;
                            code       <= '0;
                            digitCount <= '0;
                            busy       <= 1'b0;
                        end else if (valid_press) begin
                            code       <= code_first;
                            digitCount <= COUNT_WIDTH'(1);
                            if (DIGITS == 1) begin
                                state     <= DONE;
                                codeValid <= 1'b1;
                                busy      <= 1'b0;
                            end else begin
                                state <= ENTRY;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    ENTRY: begin
                        if (multi_press) begin
                            state      <= ERROR;
                            entryError <= 1'b1;
                            code       <= '0;
                            digitCount <= '0;
                            busy       <= 1'b0;
                            timer      <= '0;
                        end else if (valid_press) begin
                            code       <= code_ins;
                            digitCount <= count_inc;
                            timer      <= '0;
                            if (count_inc == COUNT_WIDTH'(DIGITS)) begin
                                state     <= DONE;
                                codeValid <= 1'b1;
                                busy      <= 1'b0;
                            end
                        end else if (timed_out) begin
                            state      <= ERROR;
                            entryError <= 1'b1;
                            code       <= '0;
                            digitCount <= '0;
                            busy       <= 1'b0;
                            timer      <= '0;
                        end else begin
                            timer <= timer + TIMER_WIDTH'(1);
                        end
                    end
                    DONE: begin
                        // Code is kept for the consumer until the next first press.
                        state      <= IDLE;
                        digitCount <= '0;
                        busy       <= 1'b0;
                        timer      <= '0;
                    end
                    default: begin
                        state      <= IDLE;
                        code       <= '0;
                        digitCount <= '0;
                        busy       <= 1'b0;
                        timer      <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_sequence_capture.sv
// Bench for button_sequence_capture: a vector table plus hand-built timeout and
// async-reset sequences. Expected outputs are queued when a vector is driven
// and popped for comparison half a cycle after the clock edge.
module tb_button_sequence_capture;

    logic       clock = 1'b0;
    logic       reset;
    logic       clear;
    logic [3:0] buttonEdge;
    logic [7:0] code;
    logic       codeValid;
    logic       entryError;
    logic [2:0] digitCount;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    button_sequence_capture #(
        .WIDTH(4), .DIGITS(4), .INDEX_WIDTH(2), .COUNT_WIDTH(3),
        .TIMEOUT_CYCLES(16), .TIMER_WIDTH(5)
    ) dut (
        .clock(clock), .reset(reset), .buttonEdge(buttonEdge), .clear(clear),
        .code(code), .codeValid(codeValid), .entryError(entryError),
        .digitCount(digitCount), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] be;
        logic       clr;
        logic [7:0] code;
        logic       cv;
        logic       ee;
        logic [2:0] cnt;
        logic       busy;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t mk(logic [3:0] be, logic clr, logic [7:0] c,
                                logic cv, logic ee, logic [2:0] cnt, logic b);
        vec_t v;
        v.be = be; v.clr = clr; v.code = c; v.cv = cv; v.ee = ee; v.cnt = cnt; v.busy = b;
        return v;
    endfunction

    task automatic check(input vec_t e, input string nm);
        n_vec++;
        if (code !== e.code || codeValid !== e.cv || entryError !== e.ee ||
            digitCount !== e.cnt || busy !== e.busy) begin
            n_err++;
            $display("FAIL %s: got code=%h cv=%b ee=%b cnt=%0d busy=%b, expected code=%h cv=%b ee=%b cnt=%0d busy=%b",
                     nm, code, codeValid, entryError, digitCount, busy,
                     e.code, e.cv, e.ee, e.cnt, e.busy);
        end
    endtask

    // Called at a negedge: drive, queue expectation, cross one posedge, compare.
    task automatic run_vec(input vec_t v, input string nm);
        vec_t e;
        exp_q.push_back(v);
        buttonEdge = v.be;
        clear      = v.clr;
        @(posedge clock);
        @(negedge clock);
        if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = exp_q.pop_front();
            check(e, nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Full code 8D with 3-cycle spacing; press during DONE ignored.
        tbl.push_back(mk(4'b0100, 0, 8'h80, 0, 0, 1, 1));
        tbl.push_back(mk(4'b0000, 0, 8'h80, 0, 0, 1, 1));
        tbl.push_back(mk(4'b0000, 0, 8'h80, 0, 0, 1, 1));
        tbl.push_back(mk(4'b0001, 0, 8'h80, 0, 0, 2, 1));
        tbl.push_back(mk(4'b0000, 0, 8'h80, 0, 0, 2, 1));
        tbl.push_back(mk(4'b0000, 0, 8'h80, 0, 0, 2, 1));
        tbl.push_back(mk(4'b1000, 0, 8'h8C, 0, 0, 3, 1));
        tbl.push_back(mk(4'b0000, 0, 8'h8C, 0, 0, 3, 1));
        tbl.push_back(mk(4'b0000, 0, 8'h8C, 0, 0, 3, 1));
        tbl.push_back(mk(4'b0010, 0, 8'h8D, 1, 0, 4, 0));
        tbl.push_back(mk(4'b0100, 0, 8'h8D, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 8'h8D, 0, 0, 0, 0));
        // Multi-press after two digits; press during ERROR ignored.
        tbl.push_back(mk(4'b0010, 0, 8'h40, 0, 0, 1, 1));
        tbl.push_back(mk(4'b1000, 0, 8'h70, 0, 0, 2, 1));
        tbl.push_back(mk(4'b0011, 0, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(4'b0001, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 8'h00, 0, 0, 0, 0));
        // Clear with a simultaneous press, then a back-to-back full entry.
        tbl.push_back(mk(4'b0001, 0, 8'h00, 0, 0, 1, 1));
        tbl.push_back(mk(4'b0100, 0, 8'h20, 0, 0, 2, 1));
        tbl.push_back(mk(4'b1000, 1, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(4'b1000, 0, 8'hC0, 0, 0, 1, 1));
        tbl.push_back(mk(4'b0100, 0, 8'hE0, 0, 0, 2, 1));
        tbl.push_back(mk(4'b0010, 0, 8'hE4, 0, 0, 3, 1));
        tbl.push_back(mk(4'b0001, 0, 8'hE4, 1, 0, 4, 0));
        tbl.push_back(mk(4'b0000, 0, 8'hE4, 0, 0, 0, 0));
        // Clear in IDLE wipes the retained code.
        tbl.push_back(mk(4'b0000, 1, 8'h00, 0, 0, 0, 0));

        reset      = 1'b1;
        clear      = 1'b0;
        buttonEdge = 4'b0000;
        #12;
        check(mk(0, 0, 8'h00, 0, 0, 0, 0), "reset_state");
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            run_vec(tbl[i], $sformatf("vec%0d", i));

        // Timeout: error exactly 16 edges after the press edge.
        run_vec(mk(4'b0001, 0, 8'h00, 0, 0, 1, 1), "to_press");
        for (int k = 1; k < 16; k++)
            run_vec(mk(4'b0000, 0, 8'h00, 0, 0, 1, 1), $sformatf("to_wait%0d", k));
        run_vec(mk(4'b0000, 0, 8'h00, 0, 1, 0, 0), "to_error");
        run_vec(mk(4'b0000, 0, 8'h00, 0, 0, 0, 0), "to_idle");

        // A press 15 cycles in reloads the timer.
        run_vec(mk(4'b0010, 0, 8'h40, 0, 0, 1, 1), "rl_press0");
        for (int k = 1; k < 15; k++)
            run_vec(mk(4'b0000, 0, 8'h40, 0, 0, 1, 1), $sformatf("rl_wait%0d", k));
        run_vec(mk(4'b0100, 0, 8'h60, 0, 0, 2, 1), "rl_press15");
        for (int k = 1; k < 16; k++)
            run_vec(mk(4'b0000, 0, 8'h60, 0, 0, 2, 1), $sformatf("rl_hold%0d", k));
        run_vec(mk(4'b0000, 0, 8'h00, 0, 1, 0, 0), "rl_error");
        run_vec(mk(4'b0000, 0, 8'h00, 0, 0, 0, 0), "rl_idle");

        // Asynchronous reset between edges mid-entry.
        run_vec(mk(4'b1000, 0, 8'hC0, 0, 0, 1, 1), "ar_d0");
        run_vec(mk(4'b0100, 0, 8'hE0, 0, 0, 2, 1), "ar_d1");
        buttonEdge = 4'b0000;
        #2 reset = 1'b1;
        #1 check(mk(0, 0, 8'h00, 0, 0, 0, 0), "ar_async");
        #1 reset = 1'b0;
        @(negedge clock);
        run_vec(mk(4'b0010, 0, 8'h40, 0, 0, 1, 1), "ar_first");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
